memory_responder: RTL and testbench

Pipelined single-port main-memory model that answers the cache fill FSM's read requests. It accepts one request per cycle (read or write) and returns read data with a `data_valid` strobe a fixed LATENCY cycles later. It sits below the I-cache/D-cache fill logic as the memory side of the `memory_address` / `memory_data_valid` interface.

---
 rtl/memory_responder.sv | 93 +++++++++
 tb/tb_memory_responder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - pipelined single-port memory model with fixed read latency
//
// Purpose: main-memory model below the cache fill logic. Accepts one read or
// write request per cycle and returns read data LATENCY cycles after the
// request, with a one-cycle data_valid strobe per read.
//
// Ports:
//   clk        - system clock, rising-edge active
//   rst_n      - asynchronous active-low reset (clears the read pipeline only)
//   enable     - request valid this cycle
//   wr         - 1 = write, 0 = read (ignored when enable = 0)
//   addr       - byte address; bits [DEPTH_LOG2:1] select the 16-bit word
//   data_in    - write data
//   data_out   - read data, 16'h0000 whenever data_valid = 0
//   data_valid - data_out holds the answer to a read issued LATENCY cycles ago
//   pending    - at least one read is in flight ahead of the output stage

module memory_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        pending
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [15:0]              mem_q [WORDS];
  logic [DEPTH_LOG2-1:0]    word_idx;
  logic                     rd_req;
  logic [LATENCY-1:0]       valid_q;
  logic [LATENCY-1:0]       valid_d;
  logic [LATENCY-1:0][15:0] data_q;
  logic [LATENCY-1:0][15:0] data_d;
  logic                     unused_addr;

  // Upper address bits and the byte bit are deliberately dropped, so
  // addresses alias modulo the array size.
  assign word_idx    = addr[DEPTH_LOG2:1];
  assign unused_addr = ^addr;
  assign rd_req      = enable & ~wr;

  // Array contents survive reset; only the read pipeline is cleared.
  always_ff @(posedge clk) begin
    if (enable && wr) begin
      mem_q[word_idx] <= data_in;
    end
  end

  // Stage 0 samples the array on the edge ending the read cycle; a write
  // cannot share that cycle, so reads see exactly the earlier writes.
  // Idle and write cycles load zero data so data_out is 0 whenever invalid.
  always_comb begin
    valid_d    = '0;
    data_d     = '0;
    valid_d[0] = rd_req;
    data_d[0]  = rd_req ? mem_q[word_idx] : 16'h0000;
    for (int i = 1; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign data_valid = valid_q[LATENCY-1];
  assign data_out   = data_q[LATENCY-1];

  // The output stage is excluded: a read sitting there is being answered.
  generate
    if (LATENCY > 1) begin : g_pending
      assign pending = |valid_q[LATENCY-2:0];
    end else begin : g_no_pending
      assign pending = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - scoreboard bench for memory_responder (LATENCY 4 and 1)

module tb_memory_responder;

  typedef struct {
    int          due;
    logic [15:0] data;
  } resp_t;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] dout4;
  logic        dv4;
  logic        pend4;
  logic [15:0] dout1;
  logic        dv1;
  logic        pend1;

  int          checks;
  int          errors;
  int          cyc;
  resp_t       q4[$];
  resp_t       q1[$];
  logic [15:0] model_mem [1024];

  memory_responder #(.LATENCY(4), .DEPTH_LOG2(10)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(dout4), .data_valid(dv4), .pending(pend4)
  );

  memory_responder #(.LATENCY(1), .DEPTH_LOG2(10)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(dout1), .data_valid(dv1), .pending(pend1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic check_outputs();
    logic [15:0] exp_d;
    logic        exp_v;
    logic        exp_p;
    exp_v = 1'b0; exp_d = 16'h0000;
    if (q4.size() > 0 && q4[0].due == cyc) begin
      exp_v = 1'b1; exp_d = q4[0].data; void'(q4.pop_front());
    end
    exp_p = 1'b0;
    foreach (q4[i]) if (q4[i].due > cyc) exp_p = 1'b1;
    chk("l4_data_valid", {15'd0, dv4}, {15'd0, exp_v});
    chk("l4_data_out", dout4, exp_d);
    chk("l4_pending", {15'd0, pend4}, {15'd0, exp_p});

    exp_v = 1'b0; exp_d = 16'h0000;
    if (q1.size() > 0 && q1[0].due == cyc) begin
      exp_v = 1'b1; exp_d = q1[0].data; void'(q1.pop_front());
    end
    exp_p = 1'b0;
    foreach (q1[i]) if (q1[i].due > cyc) exp_p = 1'b1;
    chk("l1_data_valid", {15'd0, dv1}, {15'd0, exp_v});
    chk("l1_data_out", dout1, exp_d);
    chk("l1_pending", {15'd0, pend1}, {15'd0, exp_p});
  endtask

  // One request cycle: drive, record expectation, clock, then check.
  task automatic step(input logic e, input logic w, input logic [15:0] a, input logic [15:0] d);
    resp_t r;
    enable = e; wr = w; addr = a; data_in = d;
    if (e && !w) begin
      r.data = model_mem[a[10:1]];
      r.due = cyc + 4; q4.push_back(r);
      r.due = cyc + 1; q1.push_back(r);
    end
    if (e && w) model_mem[a[10:1]] = d;
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b0; enable = 1'b0; wr = 1'b0; addr = 16'h0000; data_in = 16'h0000;
    #2;
    chk("reset_data_out", dout4, 16'h0000);
    chk("reset_data_valid", {15'd0, dv4}, 16'h0000);
    chk("reset_pending", {15'd0, pend4}, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic
    step(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    step(1'b1, 1'b0, 16'h0010, 16'h0000);
    idle(5);

    // Burst fill, then repeated reads of one address
    step(1'b1, 1'b1, 16'h0020, 16'h1111);
    step(1'b1, 1'b1, 16'h0022, 16'h2222);
    step(1'b1, 1'b1, 16'h0024, 16'h3333);
    step(1'b1, 1'b1, 16'h0026, 16'h4444);
    step(1'b1, 1'b0, 16'h0020, 16'h0000);
    step(1'b1, 1'b0, 16'h0022, 16'h0000);
    step(1'b1, 1'b0, 16'h0024, 16'h0000);
    step(1'b1, 1'b0, 16'h0026, 16'h0000);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0024, 16'h0000);
    idle(6);

    // Ordering: write-then-read sees new data, read-then-write sees old data
    step(1'b1, 1'b1, 16'h0040, 16'h00AA);
    step(1'b1, 1'b0, 16'h0040, 16'h0000);
    step(1'b1, 1'b0, 16'h0040, 16'h0000);
    step(1'b1, 1'b1, 16'h0040, 16'h00BB);
    step(1'b1, 1'b0, 16'h0040, 16'h0000);
    idle(5);

    // Aliasing and ignored byte bit
    step(1'b1, 1'b1, 16'h0802, 16'h5A5A);
    step(1'b1, 1'b0, 16'h0002, 16'h0000);
    step(1'b1, 1'b0, 16'h0003, 16'h0000);
    idle(5);

    // Gaps: reads in cycles 0, 2, 3
    step(1'b1, 1'b0, 16'h0020, 16'h0000);
    idle(1);
    step(1'b1, 1'b0, 16'h0022, 16'h0000);
    step(1'b1, 1'b0, 16'h0024, 16'h0000);
    idle(6);

    // Reset mid-flight: reads in cycles 0-2, reset during cycle 3
    step(1'b1, 1'b0, 16'h0020, 16'h0000);
    step(1'b1, 1'b0, 16'h0022, 16'h0000);
    step(1'b1, 1'b0, 16'h0024, 16'h0000);
    enable = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset_data_valid", {15'd0, dv4}, 16'h0000);
    chk("midreset_data_out", dout4, 16'h0000);
    chk("midreset_pending", {15'd0, pend4}, 16'h0000);
    q4.delete();
    q1.delete();
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
    idle(8);

    // Array contents survive reset
    step(1'b1, 1'b0, 16'h0010, 16'h0000);
    idle(5);

    chk("scoreboard_l4_empty", 16'(q4.size()), 16'h0000);
    chk("scoreboard_l1_empty", 16'(q1.size()), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
